vga_timing_gen: RTL

//   Multi-mode VGA raster timing generator; feeds the pattern controller (and via it the DAC wrapper).

---
 rtl/vga_timing_gen.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with four built-in modes.
// Counters, sync, blanking and strobes are all registered; the decoded outputs are
// computed from the next-state counters so they line up with hpos/vpos in the same cycle.
// A requested mode only takes effect at the frame wrap, so no frame is ever torn.
module vga_timing_gen #(
  parameter logic [1:0]  DEFAULT_MODE = 2'd0,
  parameter int unsigned FRAME_CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [1:0]             mode,
  output logic [10:0]            hpos,
  output logic [9:0]             vpos,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   hblank,
  output logic                   vblank,
  output logic                   visible,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [1:0]             active_mode
);

  typedef struct packed {
    logic [10:0] hact;
    logic [10:0] hfp;
    logic [10:0] hsw;
    logic [10:0] htot;
    logic [9:0]  vact;
    logic [9:0]  vfp;
    logic [9:0]  vsw;
    logic [9:0]  vtot;
    logic        hpol;  // asserted level of hsync
    logic        vpol;  // asserted level of vsync
  } timing_t;

  function automatic timing_t mode_timing(input logic [1:0] m);
    timing_t t;
    unique case (m)
      2'd0:    t = '{11'd640,  11'd16, 11'd96,  11'd800,  10'd480, 10'd10, 10'd2, 10'd525,
                     1'b0, 1'b0};
      2'd1:    t = '{11'd800,  11'd40, 11'd128, 11'd1056, 10'd600, 10'd1,  10'd4, 10'd628,
                     1'b1, 1'b1};
      2'd2:    t = '{11'd1024, 11'd24, 11'd136, 11'd1344, 10'd768, 10'd3,  10'd6, 10'd806,
                     1'b0, 1'b0};
      default: t = '{11'd1440, 11'd80, 11'd152, 11'd1904, 10'd900, 10'd1,  10'd3, 10'd932,
                     1'b0, 1'b1};
    endcase
    return t;
  endfunction

  localparam timing_t DefTiming = mode_timing(DEFAULT_MODE);

  logic [10:0]            hpos_q, hpos_d;
  logic [9:0]             vpos_q, vpos_d;
  logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;
  logic [1:0]             mode_q, mode_d;
  logic                   hsync_q, hsync_d, vsync_q, vsync_d;
  logic                   hblank_q, hblank_d, vblank_q, vblank_d;
  logic                   visible_q, visible_d;
  logic                   lstart_q, lstart_d, fstart_q, fstart_d;

  timing_t cur_t, nxt_t;
  logic    line_end, frame_end;
  logic [10:0] hs_start, hs_stop;
  logic [9:0]  vs_start, vs_stop;

  // Next-state counters; out-of-range positions are folded into the wrap point.
  always_comb begin
    cur_t     = mode_timing(mode_q);
    line_end  = (hpos_q >= cur_t.htot - 11'd1) || (vpos_q >= cur_t.vtot);
    frame_end = line_end && (vpos_q >= cur_t.vtot - 10'd1);
    hpos_d    = hpos_q + 11'd1;
    vpos_d    = vpos_q;
    fcnt_d    = fcnt_q;
    mode_d    = mode_q;
    if (line_end) begin
      hpos_d = '0;
      vpos_d = vpos_q + 10'd1;
    end
    if (frame_end) begin
      vpos_d = '0;
      fcnt_d = fcnt_q + FRAME_CNT_W'(1);
      mode_d = mode;
    end
  end

  // Decode sync, blanking and strobes from the next-state position under the next mode.
  always_comb begin
    nxt_t     = mode_timing(mode_d);
    hs_start  = nxt_t.hact + nxt_t.hfp;
    hs_stop   = hs_start + nxt_t.hsw;
    vs_start  = nxt_t.vact + nxt_t.vfp;
    vs_stop   = vs_start + nxt_t.vsw;
    hsync_d   = ((hpos_d >= hs_start) && (hpos_d < hs_stop)) ? nxt_t.hpol : ~nxt_t.hpol;
    vsync_d   = ((vpos_d >= vs_start) && (vpos_d < vs_stop)) ? nxt_t.vpol : ~nxt_t.vpol;
    hblank_d  = hpos_d >= nxt_t.hact;
    vblank_d  = vpos_d >= nxt_t.vact;
    visible_d = ~hblank_d & ~vblank_d;
    lstart_d  = hpos_d == 11'd0;
    fstart_d  = (hpos_d == 11'd0) && (vpos_d == 10'd0);
  end

  // State and output registers; ena=0 freezes everything, including strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hpos_q    <= '0;
      vpos_q    <= '0;
      fcnt_q    <= '0;
      mode_q    <= DEFAULT_MODE;
      hsync_q   <= ~DefTiming.hpol;
      vsync_q   <= ~DefTiming.vpol;
      hblank_q  <= 1'b0;
      vblank_q  <= 1'b0;
      visible_q <= 1'b1;
      lstart_q  <= 1'b1;
      fstart_q  <= 1'b1;
    end else if (ena) begin
      hpos_q    <= hpos_d;
      vpos_q    <= vpos_d;
      fcnt_q    <= fcnt_d;
      mode_q    <= mode_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      hblank_q  <= hblank_d;
      vblank_q  <= vblank_d;
      visible_q <= visible_d;
      lstart_q  <= lstart_d;
      fstart_q  <= fstart_d;
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign visible     = visible_q;
  assign line_start  = lstart_q;
  assign frame_start = fstart_q;
  assign frame_count = fcnt_q;
  assign active_mode = mode_q;

endmodule
